// File: rtl/sum_window.sv
// Windowed reduction of upstream registered sums: total, max and zero count
// over N_SAMPLES samples, presented on a valid/ready result port.
module sum_window #(
    parameter int N_SAMPLES = 8,
    parameter int IN_W      = 10
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clr,
    input  logic                                  in_valid,
    input  logic [IN_W-1:0]                       in_sum,
    input  logic                                  in_zero,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [IN_W+$clog2(N_SAMPLES)-1:0]     out_total,
    output logic [IN_W-1:0]                       out_max,
    output logic [$clog2(N_SAMPLES):0]            out_zeros,
    output logic [7:0]                            drop_cnt
);

    localparam int ACC_W = IN_W + $clog2(N_SAMPLES);
    localparam int CNT_W = $clog2(N_SAMPLES) + 1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t state, state_nx;

    logic [ACC_W-1:0] acc;
    logic [IN_W-1:0]  mx;
    logic [CNT_W-1:0] zeros;
    logic [CNT_W-1:0] cnt;

    logic [ACC_W-1:0] acc_nx;
    logic [IN_W-1:0]  mx_nx;
    logic [CNT_W-1:0] zeros_nx;
    logic             last;
    logic             take_first;

    assign acc_nx     = acc + ACC_W'(in_sum);
    assign mx_nx      = (in_sum > mx) ? in_sum : mx;
    assign zeros_nx   = zeros + CNT_W'(in_zero);
    assign last       = (cnt == CNT_W'(N_SAMPLES - 1));
    assign take_first = in_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (clr) begin
            state_nx = ACCUM;
        end else begin
            unique case (state)
                ACCUM: if (in_valid && last) state_nx = HOLD;
                HOLD:  if (out_ready)        state_nx = ACCUM;
                default: state_nx = ACCUM;
            endcase
        end
    end

    always_comb begin
        out_valid = (state == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            mx        <= '0;
            zeros     <= '0;
            cnt       <= '0;
            out_total <= '0;
            out_max   <= '0;
            out_zeros <= '0;
            drop_cnt  <= '0;
        end else if (clr) begin
            acc       <= '0;
            mx        <= '0;
            zeros     <= '0;
            cnt       <= '0;
            out_total <= '0;
            out_max   <= '0;
            out_zeros <= '0;
            drop_cnt  <= '0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (in_valid) begin
                        if (last) begin
                            out_total <= acc_nx;
                            out_max   <= mx_nx;
                            out_zeros <= zeros_nx;
                            acc       <= '0;
                            mx        <= '0;
                            zeros     <= '0;
                            cnt       <= '0;
                        end else begin
                            acc   <= acc_nx;
                            mx    <= mx_nx;
                            zeros <= zeros_nx;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // A sample arriving with the handshake opens the next window
                    if (take_first) begin
                        acc   <= ACC_W'(in_sum);
                        mx    <= in_sum;
                        zeros <= CNT_W'(in_zero);
                        cnt   <= CNT_W'(1);
                    end else if (in_valid && !out_ready) begin
                        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_window.sv
// Scoreboard bench for sum_window at N_SAMPLES=8, IN_W=10.
module tb_sum_window;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic [9:0]  in_sum;
    logic        in_zero;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_total;
    logic [9:0]  out_max;
    logic [3:0]  out_zeros;
    logic [7:0]  drop_cnt;

    sum_window #(.N_SAMPLES(8), .IN_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .in_zero   (in_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_total (out_total),
        .out_max   (out_max),
        .out_zeros (out_zeros),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] tot;
        logic [9:0]  mx;
        logic [3:0]  z;
    } res_t;

    res_t exp_q[$];

    logic [12:0] m_acc;
    logic [9:0]  m_max;
    logic [3:0]  m_z;
    int          m_cnt;
    int          passed = 0;
    int          total  = 0;

    task automatic model_clear();
        m_acc = '0;
        m_max = '0;
        m_z   = '0;
        m_cnt = 0;
    endtask

    task automatic model_add(input logic [9:0] s, input logic z);
        res_t r;
        m_acc = m_acc + 13'(s);
        if (s > m_max) m_max = s;
        m_z   = m_z + 4'(z);
        m_cnt = m_cnt + 1;
        if (m_cnt == 8) begin
            r.tot = m_acc;
            r.mx  = m_max;
            r.z   = m_z;
            exp_q.push_back(r);
            model_clear();
        end
    endtask

    task automatic send(input logic [9:0] s, input logic z);
        in_valid = 1'b1;
        in_sum   = s;
        in_zero  = z;
        model_add(s, z);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Compare the presented result, then hand it off (optionally with a new sample)
    task automatic check_result(input string name, input bit with_s, input logic [9:0] s);
        res_t e;
        total++;
        if (out_valid !== 1'b1)
            $display("FAIL %s out_valid got %b want 1", name, out_valid);
        else passed++;
        total++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s scoreboard empty", name);
        end else begin
            passed++;
            e = exp_q.pop_front();
            total++;
            if (out_total !== e.tot)
                $display("FAIL %s total got %0d want %0d", name, out_total, e.tot);
            else passed++;
            total++;
            if (out_max !== e.mx)
                $display("FAIL %s max got %0d want %0d", name, out_max, e.mx);
            else passed++;
            total++;
            if (out_zeros !== e.z)
                $display("FAIL %s zeros got %0d want %0d", name, out_zeros, e.z);
            else passed++;
        end
        out_ready = 1'b1;
        if (with_s) begin
            in_valid = 1'b1;
            in_sum   = s;
            in_zero  = 1'b0;
            model_add(s, 1'b0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0)
            $display("FAIL %s post-handshake out_valid got %b want 0", name, out_valid);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
        in_sum = '0; in_zero = 1'b0; out_ready = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({out_valid, out_total, out_max, out_zeros, drop_cnt} !== '0)
            $display("FAIL reset outputs got v=%b t=%0d m=%0d z=%0d d=%0d want 0",
                     out_valid, out_total, out_max, out_zeros, drop_cnt);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send(10'(i), 1'b0);
        check_result("basic", 1'b0, '0);
    endtask

    task automatic test_max_zeros();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(10'd1023, 1'b0);
        check_result("max", 1'b0, '0);
        for (int i = 0; i < 8; i++) send(10'd0, 1'b1);
        check_result("zeros", 1'b0, '0);
    endtask

    task automatic test_backpressure();
        logic [12:0] t0;
        logic [9:0]  m0;
        logic [3:0]  z0;
        bit          stable = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(10'(i * 37 + 3), 1'(i % 3 == 0));
        t0 = out_total; m0 = out_max; z0 = out_zeros;
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1;
            in_sum   = 10'($urandom_range(0, 1023));
            in_zero  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_total !== t0 ||
                out_max !== m0 || out_zeros !== z0) stable = 1'b0;
        end
        in_valid = 1'b0;
        total++;
        if (!stable) $display("FAIL bp_stable outputs changed while held");
        else passed++;
        total++;
        if (drop_cnt !== 8'd255)
            $display("FAIL bp_drop got %0d want 255", drop_cnt);
        else passed++;
        check_result("bp", 1'b0, '0);
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || exp_q.size() != 0)
            $display("FAIL bp_once out_valid got %b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_simultaneous();
        logic [7:0] d0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(10'(100 + i), 1'b0);
        d0 = drop_cnt;
        check_result("simul", 1'b1, 10'd5);
        total++;
        if (drop_cnt !== d0)
            $display("FAIL simul_drop got %0d want %0d", drop_cnt, d0);
        else passed++;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) send(10'(i + 1), 1'b1);
        check_result("simul_next", 1'b0, '0);
    endtask

    task automatic test_clear();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(10'(50 + i), 1'b0);
        clr = 1'b1; in_valid = 1'b1; in_sum = 10'd999; in_zero = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        model_clear();
        total++;
        if (out_valid !== 1'b0 || drop_cnt !== 8'd0 || out_total !== 13'd0)
            $display("FAIL clr state got v=%b d=%0d t=%0d want 0",
                     out_valid, drop_cnt, out_total);
        else passed++;
        for (int i = 0; i < 7; i++) send(10'(i * 2), 1'b0);
        total++;
        if (out_valid !== 1'b0)
            $display("FAIL clr_window early out_valid got %b want 0", out_valid);
        else passed++;
        send(10'd200, 1'b1);
        check_result("clr_window", 1'b0, '0);
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(10'(300 + i), 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, out_total, out_max, out_zeros, drop_cnt} !== '0)
            $display("FAIL async_rst got t=%0d m=%0d z=%0d want 0",
                     out_total, out_max, out_zeros);
        else passed++;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) send(10'(i + 20), 1'(i < 2));
        check_result("post_rst", 1'b0, '0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_max_zeros();
        test_backpressure();
        test_simultaneous();
        test_clear();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
